// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the Connect-style board logic.
//   - game phase encodings driven by the player-input FSM
//   - error codes reported by column_dropper
//   - column_dropper FSM state enum
//   - idx(): flat cell index of (row, col), row 0 at the bottom
package game_pkg;

   // Game phase (the "state" input of column_dropper)
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_P1   = 2'b01;
   localparam logic [1:0] ST_P2   = 2'b10;
   localparam logic [1:0] ST_RSVD = 2'b11;

   // Error reasons
   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_RANGE = 2'b01;
   localparam logic [1:0] ERR_FULL  = 2'b10;
   localparam logic [1:0] ERR_TURN  = 2'b11;

   typedef enum logic [1:0] {
      FSM_IDLE  = 2'b00,
      FSM_CHECK = 2'b01,
      FSM_DONE  = 2'b10,
      FSM_ERROR = 2'b11
   } fsm_t;

   // Flat bit position of a board cell; cols is the board width.
   function automatic int idx(input int row, input int col, input int cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/column_height_bank.sv
// column_height_bank: one fill-height counter per board column.
// Ports:
//   clk, reset     clock, asynchronous active-low reset (heights -> 0)
//   inc            per-column increment enable (caller only raises it
//                  for a non-full column)
//   heights        all counters, column c at [c*ROW_W +: ROW_W]
//   col_full       column c has reached ROWS discs
//   all_full_next  every column will be full after this cycle's increments;
//                  lets the caller register board_full in step with heights
module column_height_bank #(
   parameter int COLS  = 4,
   parameter int ROWS  = 4,
   parameter int ROW_W = $clog2(ROWS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [COLS-1:0]       inc,
   output logic [COLS*ROW_W-1:0] heights,
   output logic [COLS-1:0]       col_full,
   output logic                  all_full_next
);

   logic [ROW_W-1:0] height_q [COLS];
   logic [COLS-1:0]  full_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < COLS; c++) height_q[c] <= '0;
      end else begin
         for (int c = 0; c < COLS; c++) begin
            if (inc[c]) height_q[c] <= height_q[c] + ROW_W'(1);
         end
      end
   end

   always_comb begin
      heights   = '0;
      col_full  = '0;
      full_next = '0;
      for (int c = 0; c < COLS; c++) begin
         heights[c*ROW_W +: ROW_W] = height_q[c];
         col_full[c]  = (height_q[c] == ROW_W'(ROWS));
         full_next[c] = ((height_q[c] + ROW_W'(inc[c])) == ROW_W'(ROWS));
      end
      all_full_next = &full_next;
   end

endmodule

// File: rtl/column_dropper.sv
// column_dropper: validates a drop request and stacks a disc in the lowest
// free row of the chosen column.
// Ports:
//   clk, reset         clock, asynchronous active-low reset (clears everything)
//   state              game phase (00 idle, 01 P1, 10 P2, 11 reserved)
//   in_column          requested column, sampled only when a drop is accepted
//   drop_req           drop strobe, honoured only while idle
//   throw_again        acknowledges an error and returns to idle
//   out_gameboard      occupancy map, bit row*COLS+col, row 0 at the bottom
//   out_players_cells  owner map (0 = P1, 1 = P2), valid where occupied
//   placed_row         row of the last successful drop
//   drop_done          one-cycle pulse after a placement
//   busy               FSM not idle
//   invalid_column     held while an error awaits throw_again
//   err_code           error reason (see game_pkg)
//   next_player        player expected to move (0 = P1, 1 = P2)
//   board_full         every column holds ROWS discs
//   fsm_state          current FSM state, for observation
// Handshake: drop_req is accepted only with busy low; the outcome appears
// two cycles later as either a drop_done pulse or invalid_column held high
// until throw_again. Requests while busy are dropped, not queued.
module column_dropper
   import game_pkg::*;
#(
   parameter int COLS  = 4,
   parameter int ROWS  = 4,
   parameter int COL_W = ($clog2(COLS) < 1) ? 1 : $clog2(COLS),
   parameter int ROW_W = $clog2(ROWS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           state,
   input  logic [COL_W-1:0]     in_column,
   input  logic                 drop_req,
   input  logic                 throw_again,
   output logic [ROWS*COLS-1:0] out_gameboard,
   output logic [ROWS*COLS-1:0] out_players_cells,
   output logic [ROW_W-1:0]     placed_row,
   output logic                 drop_done,
   output logic                 busy,
   output logic                 invalid_column,
   output logic [1:0]           err_code,
   output logic                 next_player,
   output logic                 board_full,
   output logic [1:0]           fsm_state
);

   fsm_t fsm_q, fsm_d;

   logic [COL_W-1:0]     col_q;
   logic [1:0]           phase_q;
   logic [ROWS*COLS-1:0] board_q, owner_q, cell_mask;
   logic [ROW_W-1:0]     placed_row_q, height_sel;
   logic                 next_player_q, invalid_q, board_full_q;
   logic [1:0]           err_q, check_err;
   logic                 sel_full, in_range, turn_bad, legal;
   logic [COLS-1:0]      inc, col_full;
   logic [COLS*ROW_W-1:0] heights;
   logic                 all_full_next;

   column_height_bank #(.COLS(COLS), .ROWS(ROWS), .ROW_W(ROW_W)) u_heights (
      .clk           (clk),
      .reset         (reset),
      .inc           (inc),
      .heights       (heights),
      .col_full      (col_full),
      .all_full_next (all_full_next)
   );

   // Checks on the latched request; turn errors take priority over range,
   // range over full.
   always_comb begin
      height_sel = '0;
      sel_full   = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         if (col_q == COL_W'(c)) begin
            height_sel = heights[c*ROW_W +: ROW_W];
            sel_full   = col_full[c];
         end
      end
      in_range = (int'(col_q) < COLS);
      turn_bad = (phase_q == ST_IDLE) || (phase_q == ST_RSVD) ||
                 ((phase_q == ST_P2) != next_player_q);
      if (turn_bad)      check_err = ERR_TURN;
      else if (!in_range) check_err = ERR_RANGE;
      else if (sel_full) check_err = ERR_FULL;
      else               check_err = ERR_NONE;
      legal = (fsm_q == FSM_CHECK) && (check_err == ERR_NONE);

      inc       = '0;
      cell_mask = '0;
      for (int c = 0; c < COLS; c++) begin
         inc[c] = legal && (col_q == COL_W'(c));
         for (int r = 0; r < ROWS; r++) begin
            cell_mask[idx(r, c, COLS)] = legal && (col_q == COL_W'(c)) &&
                                         (height_sel == ROW_W'(r));
         end
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         FSM_IDLE:  if (drop_req) fsm_d = FSM_CHECK;
         FSM_CHECK: fsm_d = (check_err == ERR_NONE) ? FSM_DONE : FSM_ERROR;
         FSM_DONE:  fsm_d = FSM_IDLE;
         FSM_ERROR: if (throw_again) fsm_d = FSM_IDLE;
         default:   fsm_d = FSM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) fsm_q <= FSM_IDLE;
      else        fsm_q <= fsm_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q         <= '0;
         phase_q       <= ST_IDLE;
         board_q       <= '0;
         owner_q       <= '0;
         placed_row_q  <= '0;
         next_player_q <= 1'b0;
         invalid_q     <= 1'b0;
         err_q         <= ERR_NONE;
         board_full_q  <= 1'b0;
      end else begin
         board_full_q <= all_full_next;
         case (fsm_q)
            FSM_IDLE: begin
               if (drop_req) begin
                  col_q   <= in_column;
                  phase_q <= state;
               end
            end
            FSM_CHECK: begin
               if (check_err == ERR_NONE) begin
                  board_q       <= board_q | cell_mask;
                  owner_q       <= (owner_q & ~cell_mask) |
                                   ((phase_q == ST_P2) ? cell_mask : '0);
                  placed_row_q  <= height_sel;
                  next_player_q <= ~next_player_q;
                  err_q         <= ERR_NONE;
               end else begin
                  invalid_q <= 1'b1;
                  err_q     <= check_err;
               end
            end
            FSM_ERROR: begin
               if (throw_again) begin
                  invalid_q <= 1'b0;
                  err_q     <= ERR_NONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_gameboard     = board_q;
   assign out_players_cells = owner_q;
   assign placed_row        = placed_row_q;
   assign drop_done         = (fsm_q == FSM_DONE);
   assign busy              = (fsm_q != FSM_IDLE);
   assign invalid_column    = invalid_q;
   assign err_code          = err_q;
   assign next_player       = next_player_q;
   assign board_full        = board_full_q;
   assign fsm_state         = fsm_q;

endmodule

// File: tb/tb_column_dropper.sv
module tb_column_dropper;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  game_state;
  logic [1:0]  in_column;
  logic        drop_req;
  logic        throw_again;
  logic [15:0] out_gameboard;
  logic [15:0] out_players_cells;
  logic [2:0]  placed_row;
  logic        drop_done;
  logic        busy;
  logic        invalid_column;
  logic [1:0]  err_code;
  logic        next_player;
  logic        board_full;
  logic [1:0]  fsm_state;

  int vectors    = 0;
  int miscompares = 0;

  column_dropper dut (
    .clk               (clk),
    .reset             (reset),
    .state             (game_state),
    .in_column         (in_column),
    .drop_req          (drop_req),
    .throw_again       (throw_again),
    .out_gameboard     (out_gameboard),
    .out_players_cells (out_players_cells),
    .placed_row        (placed_row),
    .drop_done         (drop_done),
    .busy              (busy),
    .invalid_column    (invalid_column),
    .err_code          (err_code),
    .next_player       (next_player),
    .board_full        (board_full),
    .fsm_state         (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; drop_req = 1'b0; throw_again = 1'b0;
    game_state = 2'b00; in_column = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the negedge inside the CHECK cycle.
  task automatic start_drop(input logic [1:0] st, input logic [1:0] col);
    @(negedge clk);
    game_state = st; in_column = col; drop_req = 1'b1;
    @(negedge clk);
    drop_req = 1'b0;
  endtask

  task automatic clear_error();
    @(negedge clk);
    throw_again = 1'b1;
    @(negedge clk);
    throw_again = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; drop_req = 1'b0; throw_again = 1'b0;
    game_state = 2'b00; in_column = 2'd0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({out_gameboard, out_players_cells} !== 32'h0) begin
      $display("FAIL reset_maps: got %h/%h want 0/0", out_gameboard, out_players_cells); miscompares++;
    end
    vectors++;
    if ({placed_row, drop_done, busy, invalid_column, err_code, next_player, board_full, fsm_state} !== 12'h0) begin
      $display("FAIL reset_flags: row=%0d done=%b busy=%b inv=%b err=%b np=%b full=%b fsm=%0d want all 0",
               placed_row, drop_done, busy, invalid_column, err_code, next_player, board_full, fsm_state);
      miscompares++;
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_drop();
    start_drop(2'b01, 2'd0);
    vectors++;
    if (busy !== 1'b1 || drop_done !== 1'b0 || out_gameboard !== 16'h0000) begin
      $display("FAIL first_check_cycle: busy=%b done=%b board=%h want 1/0/0000", busy, drop_done, out_gameboard);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (drop_done !== 1'b1 || placed_row !== 3'd0 || out_gameboard !== 16'h0001 ||
        out_players_cells !== 16'h0000 || next_player !== 1'b1) begin
      $display("FAIL first_drop: done=%b row=%0d board=%h own=%h np=%b want 1/0/0001/0000/1",
               drop_done, placed_row, out_gameboard, out_players_cells, next_player);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (drop_done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL first_done_pulse: done=%b busy=%b want 0/0", drop_done, busy); miscompares++;
    end
  endtask

  task automatic test_column_fill();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      start_drop((i % 2 == 0) ? 2'b01 : 2'b10, 2'd0);
      @(negedge clk);
      vectors++;
      if (drop_done !== 1'b1 || placed_row !== 3'(i)) begin
        $display("FAIL col0_drop%0d: done=%b row=%0d want 1/%0d", i, drop_done, placed_row, i);
        miscompares++;
      end
    end
    vectors++;
    if (out_gameboard !== 16'h1111 || out_players_cells !== 16'h1010 || next_player !== 1'b0) begin
      $display("FAIL col0_stack: board=%h own=%h np=%b want 1111/1010/0", out_gameboard, out_players_cells, next_player);
      miscompares++;
    end
    start_drop(2'b01, 2'd0);
    @(negedge clk);
    vectors++;
    if (invalid_column !== 1'b1 || err_code !== 2'b10 || drop_done !== 1'b0 ||
        out_gameboard !== 16'h1111 || fsm_state !== 2'd3) begin
      $display("FAIL col0_full_err: inv=%b err=%b done=%b board=%h fsm=%0d want 1/10/0/1111/3",
               invalid_column, err_code, drop_done, out_gameboard, fsm_state);
      miscompares++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (invalid_column !== 1'b1 || busy !== 1'b1 || err_code !== 2'b10) begin
      $display("FAIL error_hold: inv=%b busy=%b err=%b want 1/1/10", invalid_column, busy, err_code);
      miscompares++;
    end
  endtask

  task automatic test_throw_again_priority();
    @(negedge clk);
    throw_again = 1'b1; drop_req = 1'b1; game_state = 2'b01; in_column = 2'd3;
    @(negedge clk);
    throw_again = 1'b0; drop_req = 1'b0;
    vectors++;
    if (busy !== 1'b0 || invalid_column !== 1'b0 || err_code !== 2'b00) begin
      $display("FAIL throw_again_clear: busy=%b inv=%b err=%b want 0/0/00", busy, invalid_column, err_code);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || out_gameboard !== 16'h1111) begin
      $display("FAIL throw_again_no_drop: busy=%b board=%h want 0/1111", busy, out_gameboard);
      miscompares++;
    end
    start_drop(2'b01, 2'd3);
    @(negedge clk);
    vectors++;
    if (drop_done !== 1'b1 || placed_row !== 3'd0 || out_gameboard !== 16'h1119 || next_player !== 1'b1) begin
      $display("FAIL retry_col3: done=%b row=%0d board=%h np=%b want 1/0/1119/1",
               drop_done, placed_row, out_gameboard, next_player);
      miscompares++;
    end
  endtask

  task automatic test_wrong_turn();
    start_drop(2'b10, 2'd1);
    @(negedge clk);
    vectors++;
    if (drop_done !== 1'b1 || out_gameboard !== 16'h111B || out_players_cells !== 16'h1012 || next_player !== 1'b0) begin
      $display("FAIL p2_col1: done=%b board=%h own=%h np=%b want 1/111b/1012/0",
               drop_done, out_gameboard, out_players_cells, next_player);
      miscompares++;
    end
    start_drop(2'b10, 2'd1);
    @(negedge clk);
    vectors++;
    if (err_code !== 2'b11 || invalid_column !== 1'b1 || next_player !== 1'b0 || out_gameboard !== 16'h111B) begin
      $display("FAIL wrong_player: err=%b inv=%b np=%b board=%h want 11/1/0/111b",
               err_code, invalid_column, next_player, out_gameboard);
      miscompares++;
    end
    clear_error();
    start_drop(2'b00, 2'd2);
    @(negedge clk);
    vectors++;
    if (err_code !== 2'b11 || next_player !== 1'b0 || out_gameboard !== 16'h111B) begin
      $display("FAIL idle_phase: err=%b np=%b board=%h want 11/0/111b", err_code, next_player, out_gameboard);
      miscompares++;
    end
    clear_error();
    start_drop(2'b11, 2'd2);
    @(negedge clk);
    vectors++;
    if (err_code !== 2'b11 || next_player !== 1'b0) begin
      $display("FAIL reserved_phase: err=%b np=%b want 11/0", err_code, next_player); miscompares++;
    end
    clear_error();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    start_drop(2'b01, 2'd0);
    in_column = 2'd2; drop_req = 1'b1; game_state = 2'b10;
    @(negedge clk);
    drop_req = 1'b0;
    vectors++;
    if (drop_done !== 1'b1 || out_gameboard !== 16'h0001 || placed_row !== 3'd0) begin
      $display("FAIL busy_req_col_change: done=%b board=%h row=%0d want 1/0001/0",
               drop_done, out_gameboard, placed_row);
      miscompares++;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || out_gameboard !== 16'h0001 || next_player !== 1'b1) begin
      $display("FAIL busy_req_not_queued: busy=%b board=%h np=%b want 0/0001/1", busy, out_gameboard, next_player);
      miscompares++;
    end
  endtask

  task automatic test_board_full();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      start_drop((i % 2 == 0) ? 2'b01 : 2'b10, 2'(i % 4));
      @(negedge clk);
      vectors++;
      if (drop_done !== 1'b1 || placed_row !== 3'(i / 4) || board_full !== (i == 15)) begin
        $display("FAIL fill_drop%0d: done=%b row=%0d full=%b want 1/%0d/%b",
                 i, drop_done, placed_row, board_full, i / 4, (i == 15));
        miscompares++;
      end
    end
    vectors++;
    if (out_gameboard !== 16'hFFFF || out_players_cells !== 16'hAAAA || next_player !== 1'b0) begin
      $display("FAIL full_maps: board=%h own=%h np=%b want ffff/aaaa/0", out_gameboard, out_players_cells, next_player);
      miscompares++;
    end
    start_drop(2'b01, 2'd2);
    @(negedge clk);
    vectors++;
    if (err_code !== 2'b10 || invalid_column !== 1'b1 || board_full !== 1'b1 || out_gameboard !== 16'hFFFF) begin
      $display("FAIL drop_on_full: err=%b inv=%b full=%b board=%h want 10/1/1/ffff",
               err_code, invalid_column, board_full, out_gameboard);
      miscompares++;
    end
    clear_error();
  endtask

  task automatic test_reset_mid_check();
    apply_reset();
    start_drop(2'b01, 2'd0);
    @(negedge clk);
    start_drop(2'b10, 2'd1);
    vectors++;
    if (fsm_state !== 2'd1 || out_gameboard !== 16'h0001) begin
      $display("FAIL pre_reset_check: fsm=%0d board=%h want 1/0001", fsm_state, out_gameboard); miscompares++;
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (out_gameboard !== 16'h0 || out_players_cells !== 16'h0 || busy !== 1'b0 ||
        next_player !== 1'b0 || fsm_state !== 2'd0 || drop_done !== 1'b0) begin
      $display("FAIL async_reset: board=%h own=%h busy=%b np=%b fsm=%0d done=%b want all 0",
               out_gameboard, out_players_cells, busy, next_player, fsm_state, drop_done);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (out_gameboard !== 16'h0 || busy !== 1'b0 || next_player !== 1'b0 || drop_done !== 1'b0) begin
      $display("FAIL after_reset_release: board=%h busy=%b np=%b done=%b want 0/0/0/0",
               out_gameboard, busy, next_player, drop_done);
      miscompares++;
    end
  endtask

  initial begin
    reset = 1'b0; drop_req = 1'b0; throw_again = 1'b0;
    game_state = 2'b00; in_column = 2'd0;
    test_reset();
    test_first_drop();
    test_column_fill();
    test_throw_again_priority();
    test_wrong_turn();
    test_back_to_back();
    test_board_full();
    test_reset_mid_check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
